// File: rtl/regfile_2r1w_param.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_2r1w_param
//  Purpose  : Parametrised register file with DEPTH x WIDTH storage, one
//             synchronous write port and two registered read ports (A, B).
//             Out-of-range writes are dropped and flagged on wr_err for one
//             cycle. Out-of-range reads return zero. With ZERO_R0=1, register
//             0 is hard-wired to zero and silently ignores writes.
//  Macro    : REGFILE_BYPASS_EN - when defined, a read that hits the register
//             being written in the same cycle returns the new write data
//             (write-first). When undefined, it returns the old contents
//             (read-first). Storage behaviour is identical in both builds.
//  Ports    : clk        rising-edge clock
//             reset_n    synchronous reset, active-low
//             wr_en      write strobe
//             wr_sel     write register index   [SEL_W]
//             wr_data    write data             [WIDTH]
//             rd_en      read request, both ports
//             rd_sel_a   port A register index  [SEL_W]
//             rd_sel_b   port B register index  [SEL_W]
//             rd_data_a  registered port A data [WIDTH]
//             rd_data_b  registered port B data [WIDTH]
//             rd_valid   rd_data_a/b loaded by the previous cycle's rd_en
//             wr_err     previous cycle's write was dropped (out of range)
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_2r1w_param #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 8,
   parameter int SEL_W   = 3,
   parameter int ZERO_R0 = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_en,
   input  logic [SEL_W-1:0] wr_sel,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [SEL_W-1:0] rd_sel_a,
   input  logic [SEL_W-1:0] rd_sel_b,
   output logic [WIDTH-1:0] rd_data_a,
   output logic [WIDTH-1:0] rd_data_b,
   output logic             rd_valid,
   output logic             wr_err
);

   // DEPTH always fits in SEL_W+1 bits because 2**SEL_W >= DEPTH.
   localparam logic [SEL_W:0] c_DEPTH = (SEL_W+1)'(DEPTH);
   // First register that holds real storage; r0 is skipped when hard-wired.
   localparam int             c_FIRST = (ZERO_R0 != 0) ? 1 : 0;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_data_a;
   logic [WIDTH-1:0] r_rd_data_b;
   logic             r_rd_valid;
   logic             r_wr_err;

   logic             w_wr_oor;
   logic [WIDTH-1:0] w_lookup_a;
   logic [WIDTH-1:0] w_lookup_b;
   logic             w_fwd_a;
   logic             w_fwd_b;
   logic [WIDTH-1:0] w_rd_a;
   logic [WIDTH-1:0] w_rd_b;

   assign w_wr_oor = wr_en && ({1'b0, wr_sel} >= c_DEPTH);

`ifdef REGFILE_BYPASS_EN
   // A write that really lands in storage; protected r0 never forwards.
   logic w_wr_hit;
   assign w_wr_hit = wr_en && !w_wr_oor &&
                     !((ZERO_R0 != 0) && (wr_sel == '0));
   assign w_fwd_a  = w_wr_hit && (rd_sel_a == wr_sel);
   assign w_fwd_b  = w_wr_hit && (rd_sel_b == wr_sel);
`else
   assign w_fwd_a  = 1'b0;
   assign w_fwd_b  = 1'b0;
`endif

   // Decoded read mux: indices outside [c_FIRST, DEPTH) match nothing and
   // therefore fall through to the zero default.
   always_comb begin
      w_lookup_a = '0;
      w_lookup_b = '0;
      for (int i = c_FIRST; i < DEPTH; i++) begin
         if (rd_sel_a == SEL_W'(i)) w_lookup_a = r_mem[i];
         if (rd_sel_b == SEL_W'(i)) w_lookup_b = r_mem[i];
      end
   end

   assign w_rd_a = w_fwd_a ? wr_data : w_lookup_a;
   assign w_rd_b = w_fwd_b ? wr_data : w_lookup_b;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_rd_data_a <= '0;
         r_rd_data_b <= '0;
         r_rd_valid  <= 1'b0;
         r_wr_err    <= 1'b0;
      end else begin
         // Loop bounds exclude out-of-range and protected indices.
         for (int i = c_FIRST; i < DEPTH; i++) begin
            if (wr_en && (wr_sel == SEL_W'(i))) r_mem[i] <= wr_data;
         end
         r_wr_err   <= w_wr_oor;
         r_rd_valid <= rd_en;
         if (rd_en) begin
            r_rd_data_a <= w_rd_a;
            r_rd_data_b <= w_rd_b;
         end
      end
   end

   assign rd_data_a = r_rd_data_a;
   assign rd_data_b = r_rd_data_b;
   assign rd_valid  = r_rd_valid;
   assign wr_err    = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_2r1w_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_2r1w_param
//  Purpose  : Scoreboard bench for regfile_2r1w_param. Two instances share
//             one stimulus stream: dut0 with default parameters and dut1 with
//             WIDTH=16, DEPTH=6, SEL_W=3, ZERO_R0=1. Honours REGFILE_BYPASS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_2r1w_param;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct packed {
      logic        v;
      logic [31:0] a;
      logic [31:0] b;
      logic        e;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [2:0]  wr_sel;
   logic [31:0] wr_data;
   logic        rd_en;
   logic [2:0]  rd_sel_a;
   logic [2:0]  rd_sel_b;

   logic [31:0] a0, b0;
   logic        v0, e0;
   logic [15:0] a1, b1;
   logic        v1, e1;

   int n_checks = 0;
   int n_fail   = 0;

   exp_t q0[$];
   exp_t q1[$];

   // Reference state: architectural register values and held read data.
   logic [31:0] m      [2][8];
   logic [31:0] hold_a [2];
   logic [31:0] hold_b [2];

   always #5 clk = ~clk;

   regfile_2r1w_param #(.WIDTH(32), .DEPTH(8), .SEL_W(3), .ZERO_R0(0)) dut0 (
      .clk(clk), .reset_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel),
      .wr_data(wr_data), .rd_en(rd_en), .rd_sel_a(rd_sel_a),
      .rd_sel_b(rd_sel_b), .rd_data_a(a0), .rd_data_b(b0),
      .rd_valid(v0), .wr_err(e0)
   );

   regfile_2r1w_param #(.WIDTH(16), .DEPTH(6), .SEL_W(3), .ZERO_R0(1)) dut1 (
      .clk(clk), .reset_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel),
      .wr_data(wr_data[15:0]), .rd_en(rd_en), .rd_sel_a(rd_sel_a),
      .rd_sel_b(rd_sel_b), .rd_data_a(a1), .rd_data_b(b1),
      .rd_valid(v1), .wr_err(e1)
   );

   function automatic int dep(int k);
      return (k == 0) ? 8 : 6;
   endfunction

   function automatic logic [31:0] msk(int k);
      return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
   endfunction

   function automatic bit zr(int k);
      return (k == 1);
   endfunction

   function automatic logic [31:0] rdval(int k, int sel);
      if (sel < dep(k) && !(zr(k) && sel == 0)) return m[k][sel];
      return 32'h0;
   endfunction

   // Apply the current inputs to the reference model for one clock edge and
   // return what the DUT must show after that edge.
   function automatic exp_t model_step(int k);
      exp_t        r;
      bit          wr_ok;
      logic [31:0] wd;
      int          ws, sa, sb;
      ws = int'(wr_sel);
      sa = int'(rd_sel_a);
      sb = int'(rd_sel_b);
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) m[k][i] = 32'h0;
         hold_a[k] = 32'h0;
         hold_b[k] = 32'h0;
         r = '{v: 1'b0, a: 32'h0, b: 32'h0, e: 1'b0};
         return r;
      end
      wr_ok = wr_en && ws < dep(k) && !(zr(k) && ws == 0);
      wd    = wr_data & msk(k);
      if (rd_en) begin
         hold_a[k] = (BYP && wr_ok && sa == ws) ? wd : rdval(k, sa);
         hold_b[k] = (BYP && wr_ok && sb == ws) ? wd : rdval(k, sb);
      end
      r.v = rd_en;
      r.a = hold_a[k];
      r.b = hold_b[k];
      r.e = wr_en && ws >= dep(k);
      if (wr_ok) m[k][ws] = wd;
      return r;
   endfunction

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Monitor: one expectation per clock edge per instance.
   always @(negedge clk) begin
      exp_t x;
      if (q0.size() > 0) begin
         x = q0.pop_front();
         chk("dut0.rd_valid", {31'b0, v0}, {31'b0, x.v});
         chk("dut0.wr_err",   {31'b0, e0}, {31'b0, x.e});
         chk("dut0.rd_data_a", a0, x.a);
         chk("dut0.rd_data_b", b0, x.b);
      end
      if (q1.size() > 0) begin
         x = q1.pop_front();
         chk("dut1.rd_valid", {31'b0, v1}, {31'b0, x.v});
         chk("dut1.wr_err",   {31'b0, e1}, {31'b0, x.e});
         chk("dut1.rd_data_a", {16'b0, a1}, x.a);
         chk("dut1.rd_data_b", {16'b0, b1}, x.b);
      end
   end

   task automatic step();
      q0.push_back(model_step(0));
      q1.push_back(model_step(1));
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic wr(input int sel, input logic [31:0] d);
      idle();
      wr_en = 1'b1; wr_sel = 3'(sel); wr_data = d;
      step();
   endtask

   task automatic rd(input int sa, input int sb);
      idle();
      rd_en = 1'b1; rd_sel_a = 3'(sa); rd_sel_b = 3'(sb);
      step();
   endtask

   task automatic wr_rd(input int ws, input logic [31:0] d, input int sa, input int sb);
      idle();
      wr_en = 1'b1; wr_sel = 3'(ws); wr_data = d;
      rd_en = 1'b1; rd_sel_a = 3'(sa); rd_sel_b = 3'(sb);
      step();
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      wr_sel = '0; wr_data = '0; rd_sel_a = '0; rd_sel_b = '0;
      step();
      step();

      // Reset clears storage and overrides a concurrent write.
      wr(3, 32'hDEAD_BEEF);
      idle(); rst_n = 1'b0; wr_en = 1'b1; wr_sel = 3'd5; wr_data = 32'hCAFE_F00D;
      rd_en = 1'b1; rd_sel_a = 3'd3; rd_sel_b = 3'd5;
      step();
      rd(3, 5);
      idle(); step();

      // Basic write/read and hold when rd_en drops.
      wr(1, 32'h1111_1111);
      wr(7, 32'h7777_7777);
      rd(1, 7);
      idle(); step();
      idle(); step();

      // Same-cycle write/read hazard on both ports.
      wr(2, 32'hAAAA_0000);
      wr_rd(2, 32'h5555_FFFF, 2, 2);
      rd(2, 2);

      // Out-of-range on the 6-entry instance; sel 6 is legal on dut0.
      wr(6, 32'h0000_1234);
      idle(); step();
      rd(7, 6);
      wr(5, 32'h0000_BEEF);
      rd(5, 4);

      // Register 0: writable on dut0, hard-wired to zero on dut1.
      wr_rd(0, 32'hFFFF_FFFF, 0, 0);
      rd(0, 1);
      wr_rd(0, 32'h0BAD_0BAD, 0, 3);

      // Back-to-back reads with no bubbles.
      for (int i = 0; i < 8; i++) wr(i, 32'(i) * 32'h0101_0101);
      for (int i = 0; i < 8; i++) begin
         idle(); rd_en = 1'b1; rd_sel_a = 3'(i); rd_sel_b = 3'(7 - i);
         step();
      end
      idle(); step();

      // Randomised traffic with occasional resets.
      for (int n = 0; n < 400; n++) begin
         rst_n    = ($urandom_range(0, 49) != 0);
         wr_en    = 1'($urandom_range(0, 1));
         rd_en    = ($urandom_range(0, 3) != 0);
         wr_sel   = 3'($urandom_range(0, 7));
         rd_sel_a = ($urandom_range(0, 3) == 0) ? wr_sel : 3'($urandom_range(0, 7));
         rd_sel_b = 3'($urandom_range(0, 7));
         wr_data  = $urandom;
         step();
      end
      idle(); step();

      @(negedge clk);
      #1;
      chk("dut0 scoreboard drained", 32'(q0.size()), 32'h0);
      chk("dut1 scoreboard drained", 32'(q1.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/regfile_2r1w_param.md
Name: regfile_2r1w_param

Overview:
- Parametrised register file: DEPTH registers of WIDTH bits, one synchronous write port, two registered read ports (A, B).
- Successor to the fixed 8-entry, 32-bit combinational read-select. It adds internal storage, a write port, selectable register count and width, registered read outputs with a valid flag, and optional write-to-read forwarding.
- Sits in the CPU datapath between decode (register selects) and the ALU operand latches.

Parameters:
- WIDTH, 32, data width of each register and of all data ports.
- DEPTH, 8, number of registers; legal range 2..256; need not be a power of two.
- SEL_W, 3, select width; must satisfy 2**SEL_W >= DEPTH.
- ZERO_R0, 0, when 1, register 0 always reads 0 and ignores writes.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous reset, active-low.
- wr_en  input  1  write strobe.
- wr_sel  input  SEL_W  write register index.
- wr_data  input  WIDTH  write data.
- rd_en  input  1  read request for both ports.
- rd_sel_a  input  SEL_W  port A register index.
- rd_sel_b  input  SEL_W  port B register index.
- rd_data_a  output  WIDTH  registered port A data.
- rd_data_b  output  WIDTH  registered port B data.
- rd_valid  output  1  rd_data_a/b updated by the previous cycle's rd_en.
- wr_err  output  1  registered one-cycle pulse; the previous cycle's write was dropped (out of range).

Behaviour:
- One clock; reset is synchronous and active-low. On a clk edge with reset_n=0, all DEPTH registers clear to 0, and rd_data_a=0, rd_data_b=0, rd_valid=0, wr_err=0. Reset overrides wr_en and rd_en in the same cycle.
- Write: at an edge with wr_en=1 and wr_sel<DEPTH, reg[wr_sel] <= wr_data. This is not performed when ZERO_R0=1 and wr_sel=0; in that case wr_err stays 0 and the write is silently ignored.
- Write out of range: wr_en=1 and wr_sel>=DEPTH leaves storage unchanged, and wr_err=1 for exactly the next cycle.
- Read: at an edge with rd_en=1, rd_data_a <= value(rd_sel_a), rd_data_b <= value(rd_sel_b), and rd_valid <= 1. The value is read from pre-edge storage unless forwarding applies (see Optional Feature).
- Read latency is 1 cycle: data for a request sampled at edge N is visible after edge N and remains stable until the next rd_en edge.
- rd_en=0: rd_data_a/b hold their last value; rd_valid <= 0.
- Out-of-range read (sel>=DEPTH) returns 0. A read of register 0 returns 0 when ZERO_R0=1.
- Both ports may select the same register, including simultaneously with a write to it; no conflict results.
- Simultaneous write and read of different registers: fully independent.
- Storage holds no X after reset. Registers not written since reset read 0.
- Port-level state: rd_valid and wr_err are per-cycle flags, with no multi-cycle FSM. Storage is a flat register array; no RAM inference is required.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when rd_en=1, wr_en=1, and rd_sel_x==wr_sel (in range, and not register 0 with ZERO_R0=1) in the same cycle, rd_data_x <= wr_data. This is write-first forwarding, applied independently per port.
- Undefined: the same case returns the pre-write register contents (read-first). The new value is visible on the next read.
- Storage update is identical in both builds.

Test Plan:
- Reset: write 0xDEADBEEF to r3, assert reset_n=0 for 1 cycle with wr_en=1 to r5, then read r3 and r5 -> both 0, rd_valid=0 during reset; rd_valid=1 and data 0 one cycle after the read.
- Basic R/W, default params: write r1=0x11111111, r7=0x77777777; read A=r1, B=r7 -> next cycle rd_data_a=0x11111111, rd_data_b=0x77777777, rd_valid=1. Drop rd_en -> data held, rd_valid=0.
- Same-cycle hazard: r2=0xAAAA0000; in one cycle write r2=0x5555FFFF and read A=r2, B=r2 -> 0x5555FFFF on both with REGFILE_BYPASS_EN, 0xAAAA0000 without. The following read returns 0x5555FFFF in both builds.
- Non-power-of-two: WIDTH=16, DEPTH=6, SEL_W=3; write sel=6 data=0x1234 -> wr_err=1 for one cycle, no register changed. Read A=sel 7 -> 0x0000. Read A=sel 5 after writing 0xBEEF -> 0xBEEF.
- ZERO_R0=1: write r0=0xFFFFFFFF -> wr_err=0; read r0 -> 0 in both builds, including in the same-cycle bypass case.
- Back-to-back: rd_en held high for 8 cycles with rd_sel_a stepping 0..7 after loading reg[i]=i*0x01010101 -> rd_data_a follows with 1-cycle latency, no bubbles, rd_valid continuously 1.
